// File: rtl/pong_pkg.sv
// pong_pkg: shared match-state encoding, winner codes and the screen-centre helper
// used by the Pong core and its paddle sub-module.
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SERVE     = 3'd1,
    ST_PLAY      = 3'd2,
    ST_POINT     = 3'd3,
    ST_GAME_OVER = 3'd4
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'd0;
  localparam logic [1:0] WIN_P1   = 2'd1;
  localparam logic [1:0] WIN_P2   = 2'd2;

  function automatic int centre(input int lo, input int hi);
    return (lo + hi) / 2;
  endfunction

endpackage

// File: rtl/pong_paddle.sv
// pong_paddle: one player's paddle centre; moves SPEED per game tick, held when both
// or neither control is pressed, and clamped to [Y_MIN, Y_MAX].
module pong_paddle
  import pong_pkg::*;
#(
  parameter int COORD_W = 16,
  parameter int SPEED   = 1,
  parameter int Y_MIN   = 70,
  parameter int Y_MAX   = 480,
  parameter int Y_INIT  = 275
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               gameTick,
  input  logic               up,
  input  logic               down,
  output logic [COORD_W-1:0] paddleY
);

  localparam logic [COORD_W-1:0] L_MIN  = COORD_W'(Y_MIN);
  localparam logic [COORD_W-1:0] L_MAX  = COORD_W'(Y_MAX);
  localparam logic [COORD_W-1:0] L_INIT = COORD_W'(Y_INIT);
  localparam logic [COORD_W-1:0] L_SPD  = COORD_W'(SPEED);

  logic [COORD_W-1:0] r_y;
  logic [COORD_W-1:0] w_next;

  // Compare before stepping so the upward move never wraps below zero
  always_comb begin
    w_next = r_y;
    if (up && !down)
      w_next = (r_y >= L_MIN + L_SPD) ? (r_y - L_SPD) : L_MIN;
    else if (down && !up)
      w_next = (r_y + L_SPD >= L_MAX) ? L_MAX : (r_y + L_SPD);
  end

  always_ff @(posedge clk) begin
    if (!resetN)
      r_y <= L_INIT;
    else if (gameTick)
      r_y <= w_next;
  end

  assign paddleY = r_y;

endmodule

// File: rtl/pong_engine.sv
// pong_engine: two-player Pong core (ball physics, paddles, scoring, match FSM).
// Define PONG_AI_PLAYER2_EN to let paddle 2 track the ball instead of its buttons.
//
// state     | meaning
// IDLE      | ball parked at centre, waiting for serveReq
// SERVE     | ball parked, serve delay counts down on ticks
// PLAY      | ball physics advances every tick
// POINT     | single clk: score update and pointEvent pulse
// GAME_OVER | winner latched, ball parked, waiting for serveReq
module pong_engine
  import pong_pkg::*;
#(
  parameter int COORD_W        = 16,
  parameter int H_MIN          = 140,
  parameter int H_MAX          = 790,
  parameter int V_MIN          = 30,
  parameter int V_MAX          = 520,
  parameter int PADDLE1_X      = 200,
  parameter int PADDLE2_X      = 710,
  parameter int PADDLE_HALF    = 40,
  parameter int PADDLE_SPEED   = 1,
  parameter int BALL_SPEED_MAX = 4,
  parameter int SCORE_BITS     = 4,
  parameter int WIN_SCORE      = 5,
  parameter int SERVE_DELAY    = 60
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  gameTick,
  input  logic                  serveReq,
  input  logic                  p1Up,
  input  logic                  p1Down,
  input  logic                  p2Up,
  input  logic                  p2Down,
  output logic [COORD_W-1:0]    ballX,
  output logic [COORD_W-1:0]    ballY,
  output logic [COORD_W-1:0]    paddle1Y,
  output logic [COORD_W-1:0]    paddle2Y,
  output logic [SCORE_BITS-1:0] score1,
  output logic [SCORE_BITS-1:0] score2,
  output logic [2:0]            gameState,
  output logic [1:0]            winner,
  output logic                  pointEvent
);

  localparam int CX_I  = centre(H_MIN, H_MAX);
  localparam int CY_I  = centre(V_MIN, V_MAX);
  localparam int DLY_W = $clog2(SERVE_DELAY + 1);

  localparam logic [COORD_W-1:0] L_CX    = COORD_W'(CX_I);
  localparam logic [COORD_W-1:0] L_CY    = COORD_W'(CY_I);
  localparam logic [COORD_W-1:0] L_HMIN  = COORD_W'(H_MIN);
  localparam logic [COORD_W-1:0] L_HMAX  = COORD_W'(H_MAX);
  localparam logic [COORD_W-1:0] L_VMIN  = COORD_W'(V_MIN);
  localparam logic [COORD_W-1:0] L_VMAX  = COORD_W'(V_MAX);
  localparam logic [COORD_W-1:0] L_P1X   = COORD_W'(PADDLE1_X);
  localparam logic [COORD_W-1:0] L_P2X   = COORD_W'(PADDLE2_X);
  localparam logic [COORD_W-1:0] L_HALF  = COORD_W'(PADDLE_HALF);
  localparam logic [COORD_W-1:0] L_QTR   = COORD_W'(PADDLE_HALF / 2);
  localparam logic [COORD_W-1:0] L_DXMAX = COORD_W'(BALL_SPEED_MAX);
  localparam logic [COORD_W-1:0] L_ONE   = COORD_W'(1);
  localparam logic [COORD_W-1:0] L_TWO   = COORD_W'(2);
  localparam logic [DLY_W-1:0]   L_DLY   = DLY_W'(SERVE_DELAY - 1);
  localparam logic [SCORE_BITS-1:0] L_SMAX = '1;
  localparam logic [SCORE_BITS-1:0] L_WIN  = SCORE_BITS'(WIN_SCORE);
`ifdef PONG_AI_PLAYER2_EN
  localparam logic [COORD_W-1:0] L_PSPD  = COORD_W'(PADDLE_SPEED);
`endif

  state_t r_state, w_state_nx;
  logic [COORD_W-1:0]    r_ballX, r_ballY, r_dxMag, r_dyMag;
  logic                  r_dxRight, r_dyDown, r_serveRight, r_scorerP1, r_pointEvent;
  logic [SCORE_BITS-1:0] r_score1, r_score2;
  logic [1:0]            r_winner;
  logic [DLY_W-1:0]      r_delay;

  logic [COORD_W-1:0]    w_p1Y, w_p2Y, w_nx, w_ny, w_dist1, w_dist2, w_dxInc;
  logic                  w_hit1, w_hit2, w_goalP1, w_goalP2, w_p2Up, w_p2Down;
  logic [SCORE_BITS-1:0] w_scoreSel, w_scoreInc;

`ifdef PONG_AI_PLAYER2_EN
  assign w_p2Up   = (w_p2Y > r_ballY) ? ((w_p2Y - r_ballY) > L_PSPD) : 1'b0;
  assign w_p2Down = (r_ballY > w_p2Y) ? ((r_ballY - w_p2Y) > L_PSPD) : 1'b0;
`else
  assign w_p2Up   = p2Up;
  assign w_p2Down = p2Down;
`endif

  pong_paddle #(.COORD_W(COORD_W), .SPEED(PADDLE_SPEED), .Y_MIN(V_MIN + PADDLE_HALF),
                .Y_MAX(V_MAX - PADDLE_HALF), .Y_INIT(CY_I)) u_paddle1 (
    .clk(clk), .resetN(resetN), .gameTick(gameTick), .up(p1Up), .down(p1Down), .paddleY(w_p1Y));

  pong_paddle #(.COORD_W(COORD_W), .SPEED(PADDLE_SPEED), .Y_MIN(V_MIN + PADDLE_HALF),
                .Y_MAX(V_MAX - PADDLE_HALF), .Y_INIT(CY_I)) u_paddle2 (
    .clk(clk), .resetN(resetN), .gameTick(gameTick), .up(w_p2Up), .down(w_p2Down), .paddleY(w_p2Y));

  // Candidate next position; leftward/upward steps floor at zero rather than wrap
  assign w_nx = r_dxRight ? (r_ballX + r_dxMag) : ((r_ballX >= r_dxMag) ? (r_ballX - r_dxMag) : '0);
  assign w_ny = r_dyDown  ? (r_ballY + r_dyMag) : ((r_ballY >= r_dyMag) ? (r_ballY - r_dyMag) : '0);
  assign w_dist1 = (r_ballY >= w_p1Y) ? (r_ballY - w_p1Y) : (w_p1Y - r_ballY);
  assign w_dist2 = (r_ballY >= w_p2Y) ? (r_ballY - w_p2Y) : (w_p2Y - r_ballY);
  assign w_hit1  = !r_dxRight && (r_ballX >= L_P1X) && (w_nx <= L_P1X) && (w_dist1 <= L_HALF);
  assign w_hit2  =  r_dxRight && (r_ballX <= L_P2X) && (w_nx >= L_P2X) && (w_dist2 <= L_HALF);
  assign w_goalP2 = (w_nx <= L_HMIN);
  assign w_goalP1 = (w_nx >= L_HMAX);
  assign w_dxInc  = (r_dxMag >= L_DXMAX) ? L_DXMAX : (r_dxMag + L_ONE);
  assign w_scoreSel = r_scorerP1 ? r_score1 : r_score2;
  assign w_scoreInc = (w_scoreSel == L_SMAX) ? L_SMAX : (w_scoreSel + 1'b1);

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_IDLE, ST_GAME_OVER: if (serveReq) w_state_nx = ST_SERVE;
      ST_SERVE: if (gameTick && r_delay == '0) w_state_nx = ST_PLAY;
      ST_PLAY:  if (gameTick && !w_hit1 && !w_hit2 && (w_goalP1 || w_goalP2)) w_state_nx = ST_POINT;
      ST_POINT: w_state_nx = (w_scoreInc == L_WIN) ? ST_GAME_OVER : ST_SERVE;
      default:  w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetN) r_state <= ST_IDLE;
    else         r_state <= w_state_nx;
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_ballX <= L_CX;  r_ballY <= L_CY;
      r_dxMag <= L_ONE; r_dyMag <= L_ONE;
      r_dxRight <= 1'b1; r_dyDown <= 1'b1; r_serveRight <= 1'b1; r_scorerP1 <= 1'b0;
      r_score1 <= '0; r_score2 <= '0; r_winner <= WIN_NONE;
      r_pointEvent <= 1'b0; r_delay <= L_DLY;
    end else begin
      r_pointEvent <= 1'b0;
      case (r_state)
        ST_IDLE, ST_GAME_OVER: begin
          r_ballX <= L_CX; r_ballY <= L_CY;
          if (serveReq) begin
            r_score1 <= '0; r_score2 <= '0; r_winner <= WIN_NONE;
            r_serveRight <= 1'b1; r_delay <= L_DLY;
          end
        end
        ST_SERVE: begin
          r_ballX <= L_CX; r_ballY <= L_CY;
          if (gameTick) begin
            if (r_delay == '0) begin
              r_dxRight <= r_serveRight; r_dyDown <= 1'b1;
              r_dxMag <= L_ONE; r_dyMag <= L_ONE;
            end else begin
              r_delay <= r_delay - 1'b1;
            end
          end
        end
        ST_PLAY: if (gameTick) begin
          if (w_hit1) begin
            r_ballX <= L_P1X + L_ONE; r_dxRight <= 1'b1; r_dxMag <= w_dxInc;
            r_dyMag <= (w_dist1 > L_QTR) ? L_TWO : L_ONE;
          end else if (w_hit2) begin
            r_ballX <= L_P2X - L_ONE; r_dxRight <= 1'b0; r_dxMag <= w_dxInc;
            r_dyMag <= (w_dist2 > L_QTR) ? L_TWO : L_ONE;
          end else if (w_goalP2) begin
            r_scorerP1 <= 1'b0;
          end else if (w_goalP1) begin
            r_scorerP1 <= 1'b1;
          end else begin
            r_ballX <= w_nx;
          end
          // Wall bounce is independent of the horizontal outcome of this tick
          if (w_ny <= L_VMIN) begin
            r_ballY <= L_VMIN; r_dyDown <= !r_dyDown;
          end else if (w_ny >= L_VMAX) begin
            r_ballY <= L_VMAX; r_dyDown <= !r_dyDown;
          end else begin
            r_ballY <= w_ny;
          end
        end
        ST_POINT: begin
          r_ballX <= L_CX; r_ballY <= L_CY; r_pointEvent <= 1'b1;
          if (r_scorerP1) r_score1 <= w_scoreInc;
          else            r_score2 <= w_scoreInc;
          if (w_scoreInc == L_WIN) begin
            r_winner <= r_scorerP1 ? WIN_P1 : WIN_P2;
          end else begin
            r_serveRight <= r_scorerP1;
            r_delay <= L_DLY;
          end
        end
        default: ;
      endcase
    end
  end

  assign ballX      = r_ballX;
  assign ballY      = r_ballY;
  assign paddle1Y   = w_p1Y;
  assign paddle2Y   = w_p2Y;
  assign score1     = r_score1;
  assign score2     = r_score2;
  assign gameState  = r_state;
  assign winner     = r_winner;
  assign pointEvent = r_pointEvent;

endmodule

// File: tb/tb_pong_engine.sv
// tb_pong_engine: directed rallies with hand-computed ball/paddle/score values for
// the default pong_engine parameters (CX=465, CY=275).
module tb_pong_engine;

  localparam int CX = 465;
  localparam int CY = 275;
  localparam int S_IDLE = 0, S_SERVE = 1, S_PLAY = 2, S_POINT = 3, S_OVER = 4;

  logic        clk = 1'b0;
  logic        resetN, gameTick, serveReq, p1Up, p1Down, p2Up, p2Down;
  logic [15:0] ballX, ballY, paddle1Y, paddle2Y;
  logic [3:0]  score1, score2;
  logic [2:0]  gameState;
  logic [1:0]  winner;
  logic        pointEvent;

  int n_vec  = 0;
  int n_miss = 0;

  pong_engine dut (
    .clk(clk), .resetN(resetN), .gameTick(gameTick), .serveReq(serveReq),
    .p1Up(p1Up), .p1Down(p1Down), .p2Up(p2Up), .p2Down(p2Down),
    .ballX(ballX), .ballY(ballY), .paddle1Y(paddle1Y), .paddle2Y(paddle2Y),
    .score1(score1), .score2(score2), .gameState(gameState), .winner(winner),
    .pointEvent(pointEvent));

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic check_ball(input string tag, input int x, input int y);
    check_val({tag, ".x"}, int'(ballX), x);
    check_val({tag, ".y"}, int'(ballY), y);
  endtask

  task automatic check_reset_vals(input string tag);
    check_ball(tag, CX, CY);
    check_val({tag, ".p1"}, int'(paddle1Y), CY);
    check_val({tag, ".p2"}, int'(paddle2Y), CY);
    check_val({tag, ".s1"}, int'(score1), 0);
    check_val({tag, ".s2"}, int'(score2), 0);
    check_val({tag, ".state"}, int'(gameState), S_IDLE);
    check_val({tag, ".winner"}, int'(winner), 0);
    check_val({tag, ".pev"}, int'(pointEvent), 0);
  endtask

  // Each tick: one clk with gameTick high, then one idle clk; returns on a negedge
  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) gameTick = 1'b1;
      @(negedge clk) gameTick = 1'b0;
    end
  endtask

  task automatic pulse_serve();
    @(negedge clk) serveReq = 1'b1;
    @(negedge clk) serveReq = 1'b0;
  endtask

  initial begin
    resetN = 1'b0; gameTick = 1'b0; serveReq = 1'b0;
    p1Up = 1'b0; p1Down = 1'b0; p2Up = 1'b0; p2Down = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    resetN = 1'b1;

    // Paddle clamps while idle
    p1Up = 1'b1; p2Down = 1'b1;
    do_ticks(204);
    check_val("p1_up_204", int'(paddle1Y), 71);
    check_val("p2_dn_204", int'(paddle2Y), 479);
    do_ticks(96);
    check_val("p1_top_clamp", int'(paddle1Y), 70);
    check_val("p2_bot_clamp", int'(paddle2Y), 480);
    check_ball("idle_hold", CX, CY);
    check_val("idle_state", int'(gameState), S_IDLE);
    p1Down = 1'b1; p2Down = 1'b0;
    do_ticks(1);
    check_val("p1_both_hold", int'(paddle1Y), 70);
    p1Up = 1'b0;
    do_ticks(205);
    check_val("p1_down_205", int'(paddle1Y), CY);
    p1Down = 1'b0;

    // Rally 1: serve right, paddle 2 returns, top wall, paddle 1 misses
    pulse_serve();
    check_val("serve_state", int'(gameState), S_SERVE);
    do_ticks(59);
    check_val("serve_59", int'(gameState), S_SERVE);
    do_ticks(1);
    check_val("serve_60", int'(gameState), S_PLAY);
    check_ball("play_entry", CX, CY);
    do_ticks(1);
    check_ball("first_move", 466, 276);
    do_ticks(243);
    check_ball("r1_k244", 709, 519);
    do_ticks(1);
    check_ball("p2_hit_floor", 709, 520);
    do_ticks(1);
    check_ball("p2_rebound", 707, 518);
    do_ticks(243);
    check_ball("r1_j244", 221, 32);
    do_ticks(1);
    check_ball("top_wall", 219, 30);
    do_ticks(1);
    check_ball("top_flip", 217, 32);
    do_ticks(38);
    check_ball("r1_j284", 141, 108);
    check_val("r1_still_play", int'(gameState), S_PLAY);
    do_ticks(1);
    check_val("r1_point", int'(gameState), S_POINT);
    @(negedge clk);
    check_val("r1_pev", int'(pointEvent), 1);
    check_val("r1_s2", int'(score2), 1);
    check_val("r1_s1", int'(score1), 0);
    check_val("r1_serve", int'(gameState), S_SERVE);
    check_ball("r1_centre", CX, CY);
    @(negedge clk);
    check_val("r1_pev_clear", int'(pointEvent), 0);

    // Rally 2: serve left, paddle 1 return at distance 21, paddle 2 misses
    do_ticks(60);
    check_val("r2_play", int'(gameState), S_PLAY);
    p1Down = 1'b1; p2Up = 1'b1;
    do_ticks(1);
    check_ball("serve_left", 464, 276);
    do_ticks(204);
    p1Down = 1'b0; p2Up = 1'b0;
    check_val("r2_p1", int'(paddle1Y), 480);
    check_val("r2_p2", int'(paddle2Y), CY);
    do_ticks(59);
    check_ball("r2_k264", 201, 501);
    do_ticks(1);
    check_ball("p1_hit", 201, 500);
    do_ticks(1);
    check_ball("p1_rebound", 203, 498);
    do_ticks(293);
    check_ball("r2_i294", 789, 148);
    do_ticks(1);
    check_val("r2_point", int'(gameState), S_POINT);
    @(negedge clk);
    check_val("r2_s1", int'(score1), 1);
    check_val("r2_pev", int'(pointEvent), 1);
    check_val("r2_serve", int'(gameState), S_SERVE);

    // Rallies 3-6: player 1 scores to the win
    for (int r = 2; r <= 5; r++) begin
      do_ticks(60);
      check_val("rn_play", int'(gameState), S_PLAY);
      do_ticks(324);
      check_ball("rn_k324", 789, 441);
      do_ticks(1);
      @(negedge clk);
      check_val("rn_s1", int'(score1), r);
      check_val("rn_state", int'(gameState), (r == 5) ? S_OVER : S_SERVE);
      check_val("rn_winner", int'(winner), (r == 5) ? 1 : 0);
    end

    do_ticks(5);
    check_val("over_hold", int'(gameState), S_OVER);
    check_ball("over_ball", CX, CY);
    check_val("over_winner", int'(winner), 1);
    check_val("over_s1", int'(score1), 5);
    pulse_serve();
    check_val("new_match_state", int'(gameState), S_SERVE);
    check_val("new_match_s1", int'(score1), 0);
    check_val("new_match_s2", int'(score2), 0);
    check_val("new_match_win", int'(winner), 0);
    do_ticks(60);
    do_ticks(1);
    check_ball("new_serve_right", 466, 276);
    pulse_serve();
    check_val("serve_ignored", int'(gameState), S_PLAY);
    do_ticks(2);
    check_ball("play_on", 468, 278);

    // Reset mid-play, with a tick on the same edge
    @(negedge clk) begin resetN = 1'b0; gameTick = 1'b1; end
    @(negedge clk) begin resetN = 1'b1; gameTick = 1'b0; end
    check_reset_vals("mid_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
